// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one 2-to-4 enabled decoder between four requesters.
// Drives the decoder select (Upper/Lower/Enable) plus a matching one-hot Grant.
module rr_decoder_arbiter #(
    parameter int          UUID     = 0,
    parameter string       NAME     = "",
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Req,
    output logic       Upper,
    output logic       Lower,
    output logic       Enable,
    output logic [3:0] Grant,
    output logic       Busy
);

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned CW = 8;

    // Last hold count before a forced rotation; unused when MAX_HOLD is 0.
    localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));
    localparam logic          HOLD_EN   = (MAX_HOLD != 0);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [CW-1:0]   hold_cnt, cnt_nxt;
    logic [N-1:0]    others_c;
    logic [N-1:0]    pick_src_c;
    logic [IW-1:0]   win_c;
    logic            at_limit_c;
    logic            en_nxt;
    logic [N-1:0]    grant_nxt;

    // Identification parameters carry no logic; fold them into a dead signal.
    logic unused_params_c;
    assign unused_params_c = ^{32'(UUID), 1'(NAME == "")};

    // First requester at or after start, scanning upward modulo N.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] reqs,
                                              input logic [IW-1:0] start);
        logic [IW-1:0] win;
        logic [IW-1:0] cand;
        win = start;
        for (int s = N - 1; s >= 0; s--) begin
            cand = start + IW'(s);
            if (reqs[cand]) win = cand;
        end
        return win;
    endfunction

    // Winner selection: a still-requesting owner is excluded (timeout pick).
    always_comb begin
        others_c   = Req & ~(N'(1) << idx);
        pick_src_c = ((state == S_GRANT) && Req[idx]) ? others_c : Req;
        win_c      = rr_pick(pick_src_c, ptr);
        at_limit_c = HOLD_EN && (hold_cnt == HOLD_LAST);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ptr_nxt   = ptr;
        cnt_nxt   = hold_cnt;
        case (state)
            S_IDLE: begin
                if (|Req) begin
                    state_nxt = S_GRANT;
                    idx_nxt   = win_c;
                    ptr_nxt   = win_c + IW'(1);
                    cnt_nxt   = '0;
                end
            end
            S_GRANT: begin
                if (!Req[idx]) begin
                    cnt_nxt = '0;
                    if (|Req) begin
                        idx_nxt = win_c;
                        ptr_nxt = win_c + IW'(1);
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else if (at_limit_c && (|others_c)) begin
                    idx_nxt = win_c;
                    ptr_nxt = win_c + IW'(1);
                    cnt_nxt = '0;
                end else if (at_limit_c) begin
                    cnt_nxt = '0;
                end else if (hold_cnt != '1) begin
                    cnt_nxt = hold_cnt + CW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        en_nxt    = (state_nxt == S_GRANT);
        grant_nxt = en_nxt ? (N'(1) << idx_nxt) : '0;
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= cnt_nxt;
        end
    end

    // Registered decoder select and grant outputs, all updated on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Upper  <= 1'b0;
            Lower  <= 1'b0;
            Enable <= 1'b0;
            Busy   <= 1'b0;
            Grant  <= '0;
        end else begin
            Upper  <= idx_nxt[1];
            Lower  <= idx_nxt[0];
            Enable <= en_nxt;
            Busy   <= en_nxt;
            Grant  <= grant_nxt;
        end
    end

endmodule
